// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to instruction memory
// and presents if_pc/if_inst to the IF/ID latch, with delay-slot branches and flush restart.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_VALID,
        S_DROP
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_buf, w_buf;
    logic [31:0] r_redir, w_redir;
    logic        r_br_pend, w_br_pend;
    logic [31:0] r_br_tgt, w_br_tgt;

    logic        w_req;
    logic        w_branch;
    logic [31:0] w_new_pc_al;
    logic [31:0] w_tgt_al;
    logic        w_unused;

    assign w_new_pc_al = {new_pc[31:2], 2'b00};
    assign w_tgt_al    = {branch_target_i[31:2], 2'b00};
    assign w_req       = (r_state == S_FETCH) || (r_state == S_DROP);
    assign w_branch    = branch_flag_i && !stall[2];
    assign w_unused    = &{1'b0, stall[5:3], stall[0], new_pc[1:0], branch_target_i[1:0]};

    always_comb begin
        w_state   = r_state;
        w_pc      = r_pc;
        w_buf     = r_buf;
        w_redir   = r_redir;
        w_br_pend = r_br_pend;
        w_br_tgt  = r_br_tgt;
        if (flush) begin
            // An unacked request cannot be withdrawn, so it is drained in S_DROP first.
            w_br_pend = 1'b0;
            if (w_req && !inst_ack) begin
                w_redir = w_new_pc_al;
                w_state = S_DROP;
            end else begin
                w_pc    = w_new_pc_al;
                w_state = S_FETCH;
            end
        end else begin
            if (w_branch) begin
                w_br_pend = 1'b1;
                w_br_tgt  = w_tgt_al;
            end
            case (r_state)
                S_RESET: w_state = S_FETCH;
                S_FETCH: begin
                    if (inst_ack) begin
                        w_buf   = inst_rdata;
                        w_state = S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall[1]) begin
                        if (w_branch)
                            w_pc = w_tgt_al;
                        else if (r_br_pend)
                            w_pc = r_br_tgt;
                        else
                            w_pc = r_pc + 32'd4;
                        w_br_pend = 1'b0;
                        w_state   = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (inst_ack) begin
                        w_pc    = r_redir;
                        w_state = S_FETCH;
                    end
                end
                default: w_state = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RESET;
            r_pc      <= {RESET_PC[31:2], 2'b00};
            r_buf     <= '0;
            r_redir   <= '0;
            r_br_pend <= 1'b0;
            r_br_tgt  <= '0;
        end else begin
            r_state   <= w_state;
            r_pc      <= w_pc;
            r_buf     <= w_buf;
            r_redir   <= w_redir;
            r_br_pend <= w_br_pend;
            r_br_tgt  <= w_br_tgt;
        end
    end

    assign inst_req    = w_req;
    assign inst_addr   = w_req ? r_pc : '0;
    assign if_pc       = (r_state == S_VALID) ? r_pc : '0;
    assign if_inst     = (r_state == S_VALID) ? r_buf : '0;
    assign stallreq_if = w_req;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a memory responder with programmable ack delay, a
// behavioural fetch model compared every cycle, and literal spot checks.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int errors = 0;
    int checks = 0;

    int unsigned ack_delay = 0;
    int unsigned req_cnt = 0;

    // Model: what the fetch stage is doing, in plain flags.
    bit          m_idle, m_waiting, m_dropping, m_have, m_pend;
    logic [31:0] m_pc, m_buf, m_redir, m_ptgt;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
        .inst_rdata(inst_rdata), .if_pc(if_pc), .if_inst(if_inst),
        .stallreq_if(stallreq_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit busy;
        bit took_branch;
        busy = m_waiting || m_dropping;
        took_branch = branch_flag_i && !stall[2];
        if (rst) begin
            m_idle = 1; m_waiting = 0; m_dropping = 0; m_have = 0; m_pend = 0;
            m_pc = 32'h0;
        end else if (flush) begin
            m_pend = 0;
            if (busy && !inst_ack) begin
                m_dropping = 1; m_waiting = 0;
                m_redir = new_pc & 32'hFFFF_FFFC;
            end else begin
                m_pc = new_pc & 32'hFFFF_FFFC;
                m_idle = 0; m_waiting = 1; m_dropping = 0; m_have = 0;
            end
        end else if (m_have && !stall[1]) begin
            m_pc = took_branch ? (branch_target_i & 32'hFFFF_FFFC)
                 : m_pend ? m_ptgt : m_pc + 32'd4;
            m_pend = 0; m_have = 0; m_waiting = 1;
        end else begin
            if (took_branch) begin
                m_pend = 1;
                m_ptgt = branch_target_i & 32'hFFFF_FFFC;
            end
            if (m_idle) begin
                m_idle = 0; m_waiting = 1;
            end else if (m_waiting && inst_ack) begin
                m_buf = mem(m_pc); m_waiting = 0; m_have = 1;
            end else if (m_dropping && inst_ack) begin
                m_pc = m_redir; m_dropping = 0; m_waiting = 1;
            end
        end
    endtask

    task automatic compare_model();
        bit busy;
        busy = m_waiting || m_dropping;
        chk("inst_req", {31'b0, inst_req}, {31'b0, busy});
        chk("inst_addr", inst_addr, busy ? m_pc : 32'h0);
        chk("if_pc", if_pc, m_have ? m_pc : 32'h0);
        chk("if_inst", if_inst, m_have ? m_buf : 32'h0);
        chk("stallreq_if", {31'b0, stallreq_if}, {31'b0, busy});
    endtask

    // One clock: memory responds, outputs are compared, then state advances.
    task automatic tick();
        bit prev_req;
        inst_ack   = inst_req && (req_cnt >= ack_delay);
        inst_rdata = mem(inst_addr);
        compare_model();
        prev_req = inst_req;
        @(posedge clk);
        model_update();
        if (rst || !prev_req || inst_ack) req_cnt = 0;
        else req_cnt++;
        #1;
        inst_ack = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] a);
        flush = 1'b1; new_pc = a;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        // 1: reset, zero-wait memory, sequential stream
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        tick();
        rst = 1'b0;
        chk("rst_req", {31'b0, inst_req}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_stallreq", {31'b0, stallreq_if}, 32'd0);
        ack_delay = 0;
        tick();
        chk("t1_addr0", inst_addr, 32'h0);
        chk("t1_req0", {31'b0, inst_req}, 32'd1);
        tick();
        chk("t1_inst0", if_inst, 32'hA5A5_5A5A);
        tick();
        chk("t1_addr4", inst_addr, 32'h4);
        tick(); tick();
        chk("t1_addr8", inst_addr, 32'h8);

        // 2: ack delayed 3 cycles
        ack_delay = 3;
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr_stable", inst_addr, 32'h8);
            chk("t2_stallreq", {31'b0, stallreq_if}, 32'd1);
            tick();
        end
        tick();
        chk("t2_pc", if_pc, 32'h8);

        // 3: IF/ID hold while presenting 0x10; ignored branch under ID/EX hold
        ack_delay = 0;
        flush_to(32'h10);
        tick();
        stall = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                stall = 6'b000110; branch_flag_i = 1'b1; branch_target_i = 32'h700;
            end
            tick();
            chk("t3_hold_pc", if_pc, 32'h10);
        end
        branch_flag_i = 1'b0;
        stall = '0;
        tick();
        chk("t3_next_addr", inst_addr, 32'h14);

        // 4: branch captured while fetching the delay slot
        flush_to(32'h20);
        ack_delay = 2;
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        tick(); tick();
        chk("t4_slot_pc", if_pc, 32'h20);
        tick();
        chk("t4_target", inst_addr, 32'h100);

        // 5: flush during an unacked request, pending branch discarded
        ack_delay = 0;
        flush_to(32'h40);
        ack_delay = 3;
        branch_flag_i = 1'b1; branch_target_i = 32'h300;
        tick();
        branch_flag_i = 1'b0;
        flush_to(32'h183);
        chk("t5_drop_addr", inst_addr, 32'h40);
        chk("t5_drop_inst", if_inst, 32'h0);
        tick(); tick();
        chk("t5_restart", inst_addr, 32'h180);
        ack_delay = 0;
        tick();
        chk("t5_pc", if_pc, 32'h180);
        tick();
        chk("t5_no_branch", inst_addr, 32'h184);

        // PC wrap and latest-wins redirect while draining
        flush_to(32'hFFFF_FFFF);
        tick(); tick();
        chk("wrap_addr", inst_addr, 32'h0);
        flush_to(32'h200);
        ack_delay = 4;
        tick();
        flush_to(32'h300);
        flush_to(32'h400);
        tick(); tick();
        chk("latest_redir", inst_addr, 32'h400);

        // 6: reset in S_VALID and with ack pending
        ack_delay = 0;
        flush_to(32'h500);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_if_pc", if_pc, 32'h0);
        chk("t6_req", {31'b0, inst_req}, 32'd0);
        tick();
        chk("t6_addr", inst_addr, 32'h0);
        ack_delay = 5;
        flush_to(32'h600);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6b_inst", if_inst, 32'h0);
        ack_delay = 0;
        tick();
        chk("t6b_addr", inst_addr, 32'h0);
        tick(); tick();
        chk("t6b_next", inst_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
